// File: rtl/i2s_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_if
// Purpose  : Bundles the I2S receive pins and the deserialized sample-pair
//            outputs of i2s_rx. The master side is the codec/stimulus and the
//            slave side is the receiver.
//            Macro I2S_RX_ERRCNT_EN adds the err/err_count status signals.
// Revision : 1.0  initial release
// ============================================================================
interface i2s_rx_if #(
  parameter int BITSIZE = 16
);
  logic               bclk;
  logic               lrclk;
  logic               sdata;
  logic [BITSIZE-1:0] left_chan;
  logic [BITSIZE-1:0] right_chan;
  logic               valid;
`ifdef I2S_RX_ERRCNT_EN
  logic [7:0]         err_count;
  logic               err;

  modport master (output bclk, lrclk, sdata,
                  input  left_chan, right_chan, valid, err_count, err);
  modport slave  (input  bclk, lrclk, sdata,
                  output left_chan, right_chan, valid, err_count, err);
`else
  modport master (output bclk, lrclk, sdata,
                  input  left_chan, right_chan, valid);
  modport slave  (input  bclk, lrclk, sdata,
                  output left_chan, right_chan, valid);
`endif
endinterface
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx
// Purpose  : Philips I2S receiver. Oversamples BCLK/LRCLK/SDATA on clk,
//            deserializes MSB-first words and presents a left/right pair with
//            a one-cycle valid strobe.
//            Macro I2S_RX_ERRCNT_EN adds a saturating partial-word counter
//            (err_count) and a matching err pulse.
// Revision : 1.0  initial release
// ============================================================================
module i2s_rx #(
  parameter int BITSIZE     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  i2s_rx_if.slave i2s
);

  localparam int unsigned c_CNT_W = $clog2(BITSIZE + 2);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(BITSIZE);
  localparam logic [c_CNT_W-1:0] c_SAT  = c_CNT_W'(BITSIZE + 1);

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lr_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic                   r_bclk_prev;
  logic                   r_rise;
  logic                   r_lr_s;
  logic                   r_sd_s;

  logic                   r_lr_prev;
  logic [c_CNT_W-1:0]     r_bitcnt;
  logic [BITSIZE-1:0]     r_shreg;
  logic                   r_done;
  logic                   r_done_lr;

  logic [BITSIZE-1:0]     r_left_hold;
  logic                   r_left_pending;
  logic [BITSIZE-1:0]     r_left_chan;
  logic [BITSIZE-1:0]     r_right_chan;
  logic                   r_valid;

  logic [c_CNT_W-1:0]     w_bitcnt_nxt;

  assign w_bitcnt_nxt = r_bitcnt + c_CNT_W'(1);

  // Synchronize the async pins and register a one-cycle BCLK rise event
  // together with the lrclk/sdata values seen at that rise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_sd_sync   <= '0;
      r_bclk_prev <= 1'b0;
      r_rise      <= 1'b0;
      r_lr_s      <= 1'b0;
      r_sd_s      <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i2s.bclk};
      r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0],   i2s.lrclk};
      r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0],   i2s.sdata};
      r_bclk_prev <= r_bclk_sync[SYNC_STAGES-1];
      r_rise      <= r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_prev;
      r_lr_s      <= r_lr_sync[SYNC_STAGES-1];
      r_sd_s      <= r_sd_sync[SYNC_STAGES-1];
    end
  end

  // Deserialize: an LR change restarts the word (its bit is the previous
  // slot's trailing bit); the next BITSIZE bits fill the shift register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lr_prev <= 1'b0;
      r_bitcnt  <= '0;
      r_shreg   <= '0;
      r_done    <= 1'b0;
      r_done_lr <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_rise) begin
        if (r_lr_s != r_lr_prev) begin
          r_lr_prev <= r_lr_s;
          r_bitcnt  <= '0;
        end else if (r_bitcnt != c_SAT) begin
          r_bitcnt <= w_bitcnt_nxt;
          if (w_bitcnt_nxt <= c_FULL) begin
            r_shreg <= {r_shreg[BITSIZE-2:0], r_sd_s};
          end
          if (w_bitcnt_nxt == c_FULL) begin
            r_done    <= 1'b1;
            r_done_lr <= r_lr_s;
          end
        end
      end
    end
  end

  // Commit finished words: hold left until its right partner arrives, then
  // publish the pair with a single valid strobe; orphan rights are dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_left_hold    <= '0;
      r_left_pending <= 1'b0;
      r_left_chan    <= '0;
      r_right_chan   <= '0;
      r_valid        <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_done) begin
        if (!r_done_lr) begin
          r_left_hold    <= r_shreg;
          r_left_pending <= 1'b1;
        end else if (r_left_pending) begin
          r_left_chan    <= r_left_hold;
          r_right_chan   <= r_shreg;
          r_valid        <= 1'b1;
          r_left_pending <= 1'b0;
        end
      end
    end
  end

  assign i2s.left_chan  = r_left_chan;
  assign i2s.right_chan = r_right_chan;
  assign i2s.valid      = r_valid;

`ifdef I2S_RX_ERRCNT_EN
  logic       w_partial;
  logic       r_err_armed;
  logic [7:0] r_err_count;
  logic       r_err;

  assign w_partial = r_rise & (r_lr_s != r_lr_prev) &
                     (r_bitcnt != '0) & (r_bitcnt < c_FULL);

  // Count partial words; the first one after reset is usually the tail of
  // a slot joined mid-stream and is not an error. err pulses on every
  // counted partial, including once the counter has saturated.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_armed <= 1'b0;
      r_err_count <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_partial) begin
        if (!r_err_armed) begin
          r_err_armed <= 1'b1;
        end else begin
          r_err <= 1'b1;
          if (r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
          end
        end
      end
    end
  end

  assign i2s.err_count = r_err_count;
  assign i2s.err       = r_err;
`endif

endmodule
`default_nettype wire
